// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time on a word-organised RAM, byte strobes on stores.
// Latency: response valid WAIT_CYCLES+1 cycles after acceptance; peak one request per 2+WAIT_CYCLES cycles.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, nothing is queued.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   cap_addr, cap_wdata;
    logic [3:0]    cap_wstrb;
    logic          accept, exec;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_wstrb;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic [31:0]   mem [DEPTH_WORDS];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        accept    = 1'b0;
        exec      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                        exec      = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    exec      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the access executes straight from the request inputs.
    assign acc_addr  = (state == S_IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;
    assign acc_wstrb = (state == S_IDLE) ? req_wstrb : cap_wstrb;
    assign acc_idx   = acc_addr[2 +: AW];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);
    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_wstrb  <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_wstrb <= req_wstrb;
            end
            if (exec) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_wstrb != 4'd0) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // RAM array has no reset; a reset during WAIT never reaches exec, so the store is dropped.
    always_ff @(posedge clk) begin
        if (exec && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [3:0]  req_wstrb0;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed view of a word array, errors for misaligned or out-of-range.
    task automatic model_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rd, output logic err);
        err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
        rd  = 32'd0;
        if (!err) begin
            if (strb == 4'd0) rd = model_mem[addr / 4];
            else for (int i = 0; i < 4; i++)
                if (strb[i]) model_mem[addr / 4][8*i +: 8] = wdata[8*i +: 8];
        end
    endtask

    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input int hold, output logic [31:0] rd, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_addr = addr; req_wdata = wdata; req_wstrb = strb; req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check("req_ready_seen", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 100);
        rd  = resp_rdata;
        err = resp_err;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int hold, output logic [31:0] rd, output logic err);
        logic [31:0] erd;
        logic        eerr;
        int          lat;
        txn(addr, wdata, strb, hold, rd, err, lat);
        model_op(addr, wdata, strb, erd, eerr);
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_err"}, 32'(err), 32'(eerr));
        check({tag, "_lat"}, 32'(lat), 32'(W + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, hold_rd, addr, erd;
        logic        err, eerr;
        int          n, r;

        reset = 1'b0;
        req_valid = 0; resp_ready = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        req_valid0 = 0; resp_ready0 = 0; req_addr0 = 0; req_wdata0 = 0; req_wstrb0 = 0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_valid0", 32'(resp_valid0), 32'd0);
        reset = 1'b1;

        // Give the first 16 words known contents.
        for (int i = 0; i < 16; i++) do_op("init", 32'(i * 4), $urandom, 4'hF, 0, rd, err);

        // Full-word store then load.
        do_op("t1_st", 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err);
        check("t1_st_err", 32'(err), 32'd0);
        do_op("t1_ld", 32'h10, 32'h0, 4'h0, 1, rd, err);
        check("t1_ld_val", rd, 32'hDEADBEEF);

        // Byte strobes.
        do_op("t2_st0", 32'h10, 32'h000000AA, 4'b0001, 0, rd, err);
        do_op("t2_ld0", 32'h10, 32'h0, 4'h0, 0, rd, err);
        check("t2_ld0_val", rd, 32'hDEADBEAA);
        do_op("t2_st3", 32'h10, 32'hCC000000, 4'b1000, 0, rd, err);
        do_op("t2_ld3", 32'h10, 32'h0, 4'h0, 0, rd, err);
        check("t2_ld3_val", rd, 32'hCCADBEAA);

        // Response held under backpressure; a req_valid pulse meanwhile is dropped.
        @(negedge clk);
        req_addr = 32'h10; req_wstrb = 4'h0; req_wdata = 0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 100);
        check("t3_lat", 32'(n), 32'(W + 1));
        hold_rd = resp_rdata;
        model_op(32'h10, 32'h0, 4'h0, erd, eerr);
        check("t3_rdata", hold_rd, erd);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_addr = 32'h20; req_wdata = 32'h12345678; req_wstrb = 4'hF; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            check("t3_hold_valid", 32'(resp_valid), 32'd1);
            check("t3_hold_rdata", resp_rdata, hold_rd);
            check("t3_hold_err", 32'(resp_err), 32'd0);
            check("t3_hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("t3_after_valid", 32'(resp_valid), 32'd0);
        check("t3_after_ready", 32'(req_ready), 32'd1);

        // Error cases.
        do_op("t4_mis", 32'h13, 32'h0, 4'h0, 0, rd, err);
        check("t4_mis_err", 32'(err), 32'd1);
        check("t4_mis_rdata", rd, 32'd0);
        do_op("t4_oor", 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, err);
        check("t4_oor_err", 32'(err), 32'd1);
        do_op("t4_ld0", 32'h0, 32'h0, 4'h0, 0, rd, err);

        // Reset during WAIT discards a captured store.
        do_op("t5_st", 32'h20, 32'h11, 4'hF, 0, rd, err);
        @(negedge clk);
        req_addr = 32'h20; req_wdata = 32'h55; req_wstrb = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("t5_valid_late", 32'(resp_valid), 32'd0);
        do_op("t5_ld", 32'h20, 32'h0, 4'h0, 0, rd, err);
        check("t5_ld_val", rd, 32'h11);

        // Randomised mix against the model.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(9);
            if (r < 8)       addr = 32'($urandom_range(15)) * 4;
            else if (r == 8) addr = 32'($urandom_range(15)) * 4 + 32'($urandom_range(3, 1));
            else             addr = 32'h1000 + 32'($urandom_range(1000)) * 4;
            do_op("rnd", addr, $urandom, ($urandom_range(9) < 4) ? 4'h0 : 4'($urandom), $urandom_range(2), rd, err);
        end

        // Zero wait states, back-to-back stream.
        @(negedge clk);
        req_addr0 = 32'h40; req_wdata0 = 32'hA5A5A5A5; req_wstrb0 = 4'hF;
        req_valid0 = 1'b1; resp_ready0 = 1'b1;
        n = 0;
        while (!req_ready0 && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            check("t6_ready", 32'(req_ready0), 32'(i % 2 == 0));
            check("t6_valid", 32'(resp_valid0), 32'(i % 2 == 1));
            if (i % 2 == 1) check("t6_err", 32'(resp_err0), 32'd0);
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
